// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: FSM state encoding
// and the idle level of the serial line.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Held at zero while i_clr is high so every frame starts aligned.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_tick = !i_clr && (r_cnt == CNT_LAST);

  // Free-running bit counter, wraps at the end of each bit period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serializes each word as a
// UART frame (start, LSB-first data, optional even parity, 1 or 2 stop bits).
// Outputs other than busy are registered: the combinational block computes
// the next state and the line level / strobes that belong to that next state.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int RD_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  // frame_done is registered, so it is raised one cycle before the last one
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);

  state_e                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_par, w_par_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_r_en, w_r_en_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_baud_clr;
  logic                  w_tick;
  logic [CNT_W-1:0]      w_baud_cnt;

  // The bit timer only runs while a bit is on the line
  assign w_baud_clr = (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_WAIT);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_baud_clr),
    .o_cnt (w_baud_cnt),
    .o_tick(w_tick)
  );

  // Next-state, shifter and registered-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_nxt     = r_par;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (RD_LATENCY == 0) begin
          w_shreg_nxt = fifo_r_data;
          w_par_nxt   = ^fifo_r_data;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_shreg_nxt = fifo_r_data;
        w_par_nxt   = ^fifo_r_data;
        w_state_nxt = S_START;
      end
      S_START: begin
        if (w_tick) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shreg_nxt = {1'b0, r_shreg[DATA_WIDTH-1:1]};
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if ((w_baud_cnt == CNT_PENULT) && (r_bit_cnt == STOP_LAST)) w_done_nxt = 1'b1;
        if (w_tick) begin
          if (r_bit_cnt == STOP_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = fifo_empty ? S_IDLE : S_FETCH;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_r_en_nxt = (w_state_nxt == S_FETCH);
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shreg_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = TX_IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= TX_IDLE;
      r_r_en    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par     <= w_par_nxt;
      r_tx      <= w_tx_nxt;
      r_r_en    <= w_r_en_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign fifo_r_en  = r_r_en;
  assign tx         = r_tx;
  assign frame_done = r_done;
  assign busy       = (r_state != S_IDLE);

endmodule
